// File: rtl/fp32_addsub_seq.sv
// fp32_addsub_seq: multi-cycle FP32 adder/subtractor on decoded fields, flush-to-zero,
// round-to-nearest-even, valid/ready handshakes on both sides.
module fp32_addsub_seq #(
   parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        IN_VALID_SINGLE,
   output logic        IN_READY_SINGLE,
   input  logic        SUB_SINGLE,
   input  logic        SIGN_A_SINGLE,
   input  logic        SIGN_B_SINGLE,
   input  logic [7:0]  EXP_A_SINGLE,
   input  logic [7:0]  EXP_B_SINGLE,
   input  logic [22:0] MANT_A_SINGLE,
   input  logic [22:0] MANT_B_SINGLE,
   output logic        OUT_VALID_SINGLE,
   input  logic        OUT_READY_SINGLE,
   output logic [31:0] RESULT_SINGLE,
   output logic [3:0]  FLAGS_SINGLE
);
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state;
   logic sa, sb;
   logic [7:0] ea, eb, e;
   logic [22:0] fa, fb;
   logic [27:0] m;
   logic [26:0] my;
   logic sb_in, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, special, spec_inv;
   logic [31:0] spec_res;
   logic a_big, sx;
   logic [7:0] ex, d, e_inc, er;
   logic [22:0] fx, fr;
   logic [26:0] ym, ysh, yal;
   logic up, fc;
   // special operands are resolved straight from the input fields at capture
   always_comb begin
      sb_in = SIGN_B_SINGLE ^ SUB_SINGLE;
      nan_a = (&EXP_A_SINGLE) & (|MANT_A_SINGLE);
      nan_b = (&EXP_B_SINGLE) & (|MANT_B_SINGLE);
      inf_a = (&EXP_A_SINGLE) & ~(|MANT_A_SINGLE);
      inf_b = (&EXP_B_SINGLE) & ~(|MANT_B_SINGLE);
      zero_a = ~(|EXP_A_SINGLE);
      zero_b = ~(|EXP_B_SINGLE);
      special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
      spec_inv = nan_a | nan_b | (inf_a & inf_b & (SIGN_A_SINGLE != sb_in));
      spec_res = spec_inv ? NAN_VALUE :
                 inf_a ? {SIGN_A_SINGLE, 8'hFF, 23'd0} :
                 inf_b ? {sb_in, 8'hFF, 23'd0} :
                 (zero_a & zero_b) ? {SIGN_A_SINGLE & sb_in, 31'd0} :
                 zero_a ? {sb_in, EXP_B_SINGLE, MANT_B_SINGLE} :
                 {SIGN_A_SINGLE, EXP_A_SINGLE, MANT_A_SINGLE};
   end
   always_comb begin
      a_big = {ea, fa} >= {eb, fb};
      sx = a_big ? sa : sb;
      ex = a_big ? ea : eb;
      fx = a_big ? fa : fb;
      d = ex - (a_big ? eb : ea);
      ym = {1'b1, a_big ? fb : fa, 3'b000};
      ysh = ym >> d;
      yal = ysh | {26'd0, (ysh << d) != ym};
      e_inc = e + 8'd1;
      up = m[2] & (m[1] | m[0] | m[3]);
      {fc, fr} = {1'b0, m[25:3]} + 24'(up);
      er = fc ? e_inc : e;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         IN_READY_SINGLE <= 1'b1;
         OUT_VALID_SINGLE <= 1'b0;
         RESULT_SINGLE <= '0;
         FLAGS_SINGLE <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         ea <= '0;
         eb <= '0;
         fa <= '0;
         fb <= '0;
         e <= '0;
         m <= '0;
         my <= '0;
      end else begin
         case (state)
            IDLE: if (IN_VALID_SINGLE) begin
               sa <= SIGN_A_SINGLE;
               sb <= sb_in;
               ea <= EXP_A_SINGLE;
               eb <= EXP_B_SINGLE;
               fa <= MANT_A_SINGLE;
               fb <= MANT_B_SINGLE;
               IN_READY_SINGLE <= 1'b0;
               if (special) begin
                  RESULT_SINGLE <= spec_res;
                  FLAGS_SINGLE <= {spec_inv, 3'b000};
                  OUT_VALID_SINGLE <= 1'b1;
                  state <= DONE;
               end else state <= ALIGN;
            end
            ALIGN: begin
               e <= ex;
               m <= {2'b01, fx, 3'b000};
               my <= yal;
               state <= ADD;
            end
            ADD: begin
               m <= (sa ^ sb) ? m - {1'b0, my} : m + {1'b0, my};
               state <= NORM;
            end
            NORM: if (m[27]) begin
               m <= {1'b0, m[27:2], m[1] | m[0]};
               e <= e_inc;
               if (&e_inc) begin
                  RESULT_SINGLE <= {sx, 8'hFF, 23'd0};
                  FLAGS_SINGLE <= 4'b0101;
                  OUT_VALID_SINGLE <= 1'b1;
                  state <= DONE;
               end else state <= ROUND;
            end else if (m == '0) begin
               RESULT_SINGLE <= '0;
               FLAGS_SINGLE <= '0;
               OUT_VALID_SINGLE <= 1'b1;
               state <= DONE;
            end else if (!m[26] && e > 8'd1) begin
               m <= m << 1;
               e <= e - 8'd1;
            end else if (!m[26]) begin
               RESULT_SINGLE <= {sx, 31'd0};
               FLAGS_SINGLE <= 4'b0011;
               OUT_VALID_SINGLE <= 1'b1;
               state <= DONE;
            end else state <= ROUND;
            ROUND: begin
               RESULT_SINGLE <= (&er) ? {sx, 8'hFF, 23'd0} : {sx, er, fr};
               FLAGS_SINGLE <= {1'b0, &er, 1'b0, |m[2:0]};
               OUT_VALID_SINGLE <= 1'b1;
               state <= DONE;
            end
            DONE: if (OUT_READY_SINGLE) begin
               OUT_VALID_SINGLE <= 1'b0;
               IN_READY_SINGLE <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fp32_addsub_seq.md
Name: fp32_addsub_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder/subtractor.
- Sits directly downstream of the FP32 field decoder and consumes its outputs: sign, 8-bit exponent and 23-bit mantissa for each of A and B.
- Aligns, adds, normalises and rounds the operands using a state machine, and returns a packed 32-bit result with status flags.
- Uses valid/ready handshakes on both input and output so it can be stalled by the downstream writeback.

Parameters:
- NAN_VALUE, 32'h7FC00000, canonical quiet NaN returned for every invalid/NaN result.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID_SINGLE  in  1  operand fields and SUB_SINGLE are valid.
- IN_READY_SINGLE  out  1  block can accept operands (high only in IDLE).
- SUB_SINGLE  in  1  0 = A+B, 1 = A−B (B sign inverted at capture).
- SIGN_A_SINGLE  in  1  sign of A.
- SIGN_B_SINGLE  in  1  sign of B.
- EXP_A_SINGLE  in  8  biased exponent of A.
- EXP_B_SINGLE  in  8  biased exponent of B.
- MANT_A_SINGLE  in  23  fraction of A.
- MANT_B_SINGLE  in  23  fraction of B.
- OUT_VALID_SINGLE  out  1  RESULT/FLAGS valid; held until accepted.
- OUT_READY_SINGLE  in  1  consumer accepts result.
- RESULT_SINGLE  out  32  packed {sign, exp[7:0], frac[22:0]}.
- FLAGS_SINGLE  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, IN_READY=1, OUT_VALID=0, RESULT=0, FLAGS=0.
  - Reset in any state aborts the operation in progress; no partial result ever appears.
- Accept: the operand transfer happens on the edge where IN_VALID && IN_READY.
  - All fields are registered at that edge; input changes afterwards are ignored.
- Operand classification at capture:
  - exp==0 is treated as signed zero (denormals flushed).
  - exp==255 with frac!=0 is NaN.
  - exp==255 with frac==0 is Inf.
- Special path: capture goes IDLE→DONE, so OUT_VALID rises 1 cycle after the accept edge.
  - Any NaN → NAN_VALUE, invalid=1.
  - Inf − Inf (effective) → NAN_VALUE, invalid=1.
  - Inf ± finite → that Inf.
  - Both zero → sign = effective sign A AND effective sign B.
  - One zero → the other operand unchanged.
- Normal path states: IDLE → ALIGN → ADD → NORM(1..n) → ROUND → DONE.
- ALIGN (1 cycle):
  - Swap so that X holds the operand with the larger magnitude.
  - Form 27-bit mantissas {1, frac, G, R, S}.
  - Right-shift Y by the exponent difference, OR-ing shifted-out bits into S.
  - A difference ≥ 27 leaves Y = sticky only.
- ADD (1 cycle):
  - Equal effective signs: 28-bit sum.
  - Otherwise: X−Y (never negative).
  - Result sign = sign of X.
- NORM, evaluated once per cycle in this priority order:
  - Carry (bit27): shift right 1, keep sticky, exp+1, → ROUND. If exp becomes 255 → Inf, overflow=1, inexact=1, → DONE.
  - Mantissa==0: result +0 (exact cancellation), → DONE.
  - bit26==0 and exp>1: shift left 1, exp−1, stay in NORM.
  - bit26==0 and exp==1: signed zero, underflow=1, inexact=1, → DONE.
  - Otherwise → ROUND.
- ROUND (1 cycle):
  - Round to nearest, ties to even, using G/R/S.
  - inexact = G|R|S.
  - Mantissa overflow from rounding: exp+1.
  - exp reaching 255: Inf, overflow=1.
- Latency from the accept edge to OUT_VALID = 4 + number of NORM cycles (minimum 5).
- DONE:
  - OUT_VALID=1; RESULT and FLAGS stay stable while OUT_READY=0.
  - At the edge with OUT_READY=1: OUT_VALID→0, state→IDLE.
  - No new operand is accepted in the same cycle; IN_READY rises the following cycle.
- IN_READY=0 in every state except IDLE.

Test Plan:
- Decoded 1.0 + 1.0 (exp 127, frac 0, SUB=0), OUT_READY=1 → RESULT 0x40000000, FLAGS 0, OUT_VALID exactly 5 cycles after accept.
- 1.0 − 0.75 (A 0x3F800000, B 0x3F400000, SUB=1) → 0x3E800000, FLAGS 0, two left shifts, OUT_VALID 7 cycles after accept.
- Rounding cases:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33800001 → 0x3F800001, inexact=1.
- Specials and extremes:
  - +Inf + −Inf → 0x7FC00000, invalid=1, OUT_VALID 1 cycle after accept.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 1.0 − 1.0 → 0x00000000.
- Handshake and reset:
  - Hold OUT_READY=0 for 10 cycles in DONE → RESULT and FLAGS stable, IN_READY=0; release → IN_READY=1 one cycle later.
  - Pulse RST_N low during NORM → OUT_VALID=0, RESULT=0 immediately; next operation completes correctly.
